// File: rtl/awgn_pkg.sv
// Shared widths, fixed-point positions and the scale/round helper for the
// AWGN noise output stage.
package awgn_pkg;

  localparam int F_W     = 17;
  localparam int G_W     = 16;
  localparam int G_MAG_W = 15;
  localparam int OUT_W   = 16;
  localparam int PROD_W  = 32;

  localparam int F_FRAC   = 13;
  localparam int G_FRAC   = 14;
  localparam int OUT_FRAC = 10;
  localparam int SHIFT    = F_FRAC + G_FRAC - OUT_FRAC;

  localparam logic [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) << (SHIFT - 1);

  // UQ5.27 product -> signed Q5.10, round-half-up on the magnitude.
  // The largest product plus the bias still fits in 32 bits, so the
  // magnitude can never exceed 32767.
  function automatic logic [OUT_W-1:0] scale_round(input logic [PROD_W-1:0] p,
                                                   input logic              neg);
    logic [G_MAG_W-1:0] mag;
    logic [OUT_W-1:0]   ext;
    mag = G_MAG_W'((p + ROUND_BIAS) >> SHIFT);
    ext = {1'b0, mag};
    return neg ? (OUT_W'(0) - ext) : ext;
  endfunction

endpackage

// File: rtl/awgn_pair_fifo.sv
// Synchronous FIFO holding {x1, x0} sample pairs; occupancy comes from
// wrapping pointers one bit wider than the address.
module awgn_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/awgn_noise_out.sv
// Scales cos/sin results by f, buffers the sample pairs and serialises them
// x0 then x1 onto a valid/ready stream with credit-based input back-pressure.
module awgn_noise_out
  import awgn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [F_W-1:0]   f_e,
  input  logic [G_W-1:0]   g0,
  input  logic [G_W-1:0]   g1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic              s1_v, s2_v, s3_v;
  logic [F_W-1:0]    s1_f;
  logic [G_W-1:0]    s1_g0, s1_g1;
  logic [PROD_W-1:0] s2_p0, s2_p1;
  logic              s2_n0, s2_n1;
  logic [OUT_W-1:0]  s3_x0, s3_x1;
  logic              phase;

  logic              accept;
  logic              push;
  logic              pop;
  logic              out_hs;
  logic [2*OUT_W-1:0] head;
  logic [AW:0]       fifo_count;
  logic [1:0]        inflight;
  logic [AW+1:0]     committed;

  // Every pair in the pipeline already owns a FIFO slot, so the pipeline
  // never has to stall.
  assign inflight  = 2'(s1_v) + 2'(s2_v) + 2'(s3_v);
  assign committed = (AW+2)'(fifo_count) + (AW+2)'(inflight);
  assign in_ready  = committed < (AW+2)'(FIFO_DEPTH);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s3_v  <= 1'b0;
      phase <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
      s3_v <= s2_v;
      if (out_hs) phase <= ~phase;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      s1_f  <= f_e;
      s1_g0 <= g0;
      s1_g1 <= g1;
    end
    if (s1_v) begin
      s2_p0 <= PROD_W'(s1_f) * PROD_W'(s1_g0[G_MAG_W-1:0]);
      s2_p1 <= PROD_W'(s1_f) * PROD_W'(s1_g1[G_MAG_W-1:0]);
      s2_n0 <= s1_g0[G_W-1];
      s2_n1 <= s1_g1[G_W-1];
    end
    if (s2_v) begin
      s3_x0 <= scale_round(s2_p0, s2_n0);
      s3_x1 <= scale_round(s2_p1, s2_n1);
    end
  end

  assign push = s3_v;

  awgn_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*OUT_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata ({s3_x1, s3_x0}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_hs    = out_valid && out_ready;
  assign pop       = out_hs && phase;
  assign out_data  = !out_valid ? '0 :
                     phase      ? head[2*OUT_W-1:OUT_W] : head[OUT_W-1:0];

endmodule

// File: tb/tb_awgn_noise_out.sv
// Bench for awgn_noise_out: fixed vectors, back-pressure, random stalls and
// mid-stream reset against an arithmetic reference model.
module tb_awgn_noise_out;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] f_e;
  logic [15:0] g0;
  logic [15:0] g1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int errors = 0;
  int checks = 0;

  awgn_noise_out #(.FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f_e       (f_e),
    .g0        (g0),
    .g1        (g1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [16:0] f;
    logic [15:0] g0;
    logic [15:0] g1;
    logic [15:0] x0;
    logic [15:0] x1;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  int          outstanding;
  int          out_half;
  int          accepted;
  int          emitted;
  logic        stalled_prev;
  logic [15:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [16:0] f, input logic [15:0] g);
    longint prod;
    longint mag;
    prod = longint'(f) * longint'(g[14:0]);
    mag  = (prod + 65536) / 131072;
    return g[15] ? 16'(-mag) : 16'(mag);
  endfunction

  // Called at a falling edge: sample, check, drive, advance one cycle.
  task automatic do_cycle(input logic iv, input logic ordy);
    logic        ir, ov;
    logic [15:0] od, e, a, b;
    logic [16:0] fv;
    ir = in_ready;
    ov = out_valid;
    od = out_data;
    if (stalled_prev) begin
      chk("stall_valid", 32'(ov), 32'd1);
      chk("stall_data", 32'(od), 32'(prev_data));
    end
    chk("credit", 32'(ir), 32'(outstanding < DEPTH));
    fv = 17'($urandom);
    if ($urandom_range(0, 7) == 0) fv = 17'h1FFFF;
    a = 16'($urandom);
    b = 16'($urandom);
    in_valid  = iv;
    f_e       = fv;
    g0        = a;
    g1        = b;
    out_ready = ordy;
    if (iv && ir) begin
      exp_q.push_back(model(fv, a));
      exp_q.push_back(model(fv, b));
      outstanding++;
      accepted++;
    end
    if (ov && ordy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected no sample", od);
      end else begin
        e = exp_q.pop_front();
        chk("sample", 32'(od), 32'(e));
      end
      emitted++;
      if (out_half == 1) outstanding--;
      out_half ^= 1;
    end
    stalled_prev = ov && !ordy;
    prev_data    = od;
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (!reset && dut.push && dut.fifo_count == DEPTH) begin
      errors++;
      $display("FAIL fifo_overflow: count %0d at push, required below %0d", dut.fifo_count, DEPTH);
    end
  end

  initial begin
    int n;
    int cyc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    f_e = '0; g0 = '0; g1 = '0;
    outstanding = 0; out_half = 0; accepted = 0; emitted = 0;
    stalled_prev = 1'b0; prev_data = '0;

    vecs[0] = '{17'h02000, 16'h2000, 16'hA000, 16'h0200, 16'hFE00};
    vecs[1] = '{17'h1FFFF, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h8001};
    vecs[2] = '{17'h00001, 16'h4000, 16'hC000, 16'h0000, 16'h0000};
    vecs[3] = '{17'h00400, 16'h0002, 16'h8002, 16'h0000, 16'h0000};
    vecs[4] = '{17'h00004, 16'h4000, 16'hC000, 16'h0001, 16'hFFFF};
    vecs[5] = '{17'h00003, 16'h4000, 16'h4000, 16'h0000, 16'h0000};
    vecs[6] = '{17'h08000, 16'h4000, 16'hC000, 16'h1000, 16'hF000};
    vecs[7] = '{17'h1FFFF, 16'h0001, 16'h8001, 16'h0001, 16'hFFFF};

    repeat (3) @(negedge clock);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single pairs into an idle block: exact latency and values.
    for (int i = 0; i < 8; i++) begin
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; f_e = vecs[i].f; g0 = vecs[i].g0; g1 = vecs[i].g1;
      out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("tbl_early_valid", 32'(out_valid), 32'd0);
      @(negedge clock);
      chk("tbl_x0_valid", 32'(out_valid), 32'd1);
      chk("tbl_x0", 32'(out_data), 32'(vecs[i].x0));
      @(negedge clock);
      chk("tbl_x1_valid", 32'(out_valid), 32'd1);
      chk("tbl_x1", 32'(out_data), 32'(vecs[i].x1));
      @(negedge clock);
      chk("tbl_done_valid", 32'(out_valid), 32'd0);
    end

    // Back-pressure: output blocked, input pushing.
    accepted = 0; emitted = 0;
    repeat (3 * DEPTH) do_cycle(1'b1, 1'b0);
    chk("bp_accepted", 32'(accepted), 32'(DEPTH));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (exp_q.size() != 0 && n < 8 * DEPTH) begin
      do_cycle(1'b0, 1'b1);
      n++;
    end
    chk("bp_emitted", 32'(emitted), 32'(2 * DEPTH));
    repeat (3) do_cycle(1'b0, 1'b1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);

    // Random traffic with stalls on both sides.
    accepted = 0; cyc = 0;
    while (accepted < 10000 && cyc < 70000) begin
      do_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      cyc++;
    end
    chk("rand_accepted", 32'(accepted), 32'd10000);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      do_cycle(1'b0, $urandom_range(0, 9) < 7);
      n++;
    end
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three pairs in the FIFO and two in the pipeline.
    repeat (3) do_cycle(1'b1, 1'b0);
    repeat (3) do_cycle(1'b0, 1'b0);
    repeat (2) do_cycle(1'b1, 1'b0);
    chk("pre_reset_fifo_count", 32'(dut.fifo_count), 32'd3);
    chk("pre_reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
    chk("mid_reset_in_ready", 32'(in_ready), 32'd1);
    chk("mid_reset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    outstanding = 0; out_half = 0; stalled_prev = 1'b0; emitted = 0;
    do_cycle(1'b1, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      do_cycle(1'b0, 1'b1);
      n++;
    end
    chk("post_reset_drained", 32'(exp_q.size()), 32'd0);
    chk("post_reset_emitted", 32'(emitted), 32'd2);
    repeat (3) do_cycle(1'b0, 1'b1);
    chk("post_reset_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
